// File: rtl/rx_cmd_seq.sv
// rx_cmd_seq: receive-side command sequencer. Walks each UART command frame,
// steers the frame analyzer (latch/route/address) and issues the register
// file and ALU strobes once the analyzer has captured the last routed byte.
module rx_cmd_seq #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_WIDTH   = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 rx_valid_i,
   input  logic                 rx_err_i,
   input  logic [2:0]           cmd_code_i,
   output logic                 cmd_analyze_en_o,
   output logic [1:0]           block_dir_o,
   output logic [1:0]           addr_code_o,
   output logic                 reg_wr_en_o,
   output logic                 reg_rd_en_o,
   output logic                 alu_en_o,
   output logic                 alu_clk_en_o,
   output logic                 frame_done_o,
   output logic                 frame_err_o,
   output logic                 busy_o
);

   localparam logic [2:0] CMD_WR      = 3'b001;
   localparam logic [2:0] CMD_RD      = 3'b010;
   localparam logic [2:0] CMD_ALU_OP  = 3'b011;
   localparam logic [2:0] CMD_ALU_NOP = 3'b100;

   localparam logic [1:0] DIR_CLR  = 2'b00;
   localparam logic [1:0] DIR_FUN  = 2'b01;
   localparam logic [1:0] DIR_ADDR = 2'b10;
   localparam logic [1:0] DIR_DATA = 2'b11;

   localparam logic [1:0] ACODE_NONE = 2'b00;
   localparam logic [1:0] ACODE_BYTE = 2'b01;
   localparam logic [1:0] ACODE_A0   = 2'b10;
   localparam logic [1:0] ACODE_A1   = 2'b11;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      CMD_DEC = 4'd1,
      WR_A    = 4'd2,
      WR_D    = 4'd3,
      WR_X    = 4'd4,
      RD_A    = 4'd5,
      RD_X    = 4'd6,
      OPA_W   = 4'd7,
      OPA_AD  = 4'd8,
      OPA_X   = 4'd9,
      OPB_W   = 4'd10,
      OPB_AD  = 4'd11,
      OPB_X   = 4'd12,
      FUN_W   = 4'd13,
      ALU_X   = 4'd14
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]           dir_hold_q, dir_hold_d;
   logic [1:0]           code_hold_q, code_hold_d;

   logic                 byte_ok, byte_bad, timeout, wait_err;
   logic                 route;
   logic [1:0]           route_dir, route_code;

   function automatic logic is_wait(input state_t s);
      return (s == WR_A) || (s == WR_D) || (s == RD_A) ||
             (s == OPA_W) || (s == OPB_W) || (s == FUN_W);
   endfunction

   assign byte_ok  = rx_valid_i & ~rx_err_i;
   assign byte_bad = rx_valid_i & rx_err_i;
   assign timeout  = (cnt_q == CNT_WIDTH'(TIMEOUT_CYC));
   // A good byte beats a coinciding timeout; errors only abort from wait states.
   assign wait_err = byte_bad | (~rx_valid_i & timeout);

   // State, idle counter and routing-hold registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dir_hold_q  <= DIR_CLR;
         code_hold_q <= ACODE_NONE;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dir_hold_q  <= dir_hold_d;
         code_hold_q <= code_hold_d;
      end
   end

   // Idle counter restarts on every byte and on entry to a wait state.
   always_comb begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      if (rx_valid_i || (is_wait(state_d) && (state_d != state_q))) begin
         cnt_d = '0;
      end
   end

   // Next-state and Mealy outputs; non-routing cycles replay the held code.
   always_comb begin
      state_d          = state_q;
      dir_hold_d       = dir_hold_q;
      code_hold_d      = code_hold_q;
      route            = 1'b0;
      route_dir        = DIR_CLR;
      route_code       = ACODE_NONE;
      cmd_analyze_en_o = 1'b0;
      block_dir_o      = dir_hold_q;
      addr_code_o      = code_hold_q;
      reg_wr_en_o      = 1'b0;
      reg_rd_en_o      = 1'b0;
      alu_en_o         = 1'b0;
      alu_clk_en_o     = 1'b0;
      frame_done_o     = 1'b0;
      frame_err_o      = 1'b0;
      busy_o           = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            block_dir_o      = DIR_CLR;
            addr_code_o      = ACODE_NONE;
            cmd_analyze_en_o = byte_ok;
            if (byte_ok) begin
               state_d     = CMD_DEC;
               dir_hold_d  = DIR_CLR;
               code_hold_d = ACODE_NONE;
            end
         end
         CMD_DEC: begin
            block_dir_o = DIR_CLR;
            addr_code_o = ACODE_NONE;
            case (cmd_code_i)
               CMD_WR:      state_d = WR_A;
               CMD_RD:      state_d = RD_A;
               CMD_ALU_OP:  state_d = OPA_W;
               CMD_ALU_NOP: state_d = FUN_W;
               default: begin
                  state_d     = IDLE;
                  frame_err_o = 1'b1;
               end
            endcase
         end
         WR_A, RD_A: begin
            if (wait_err) begin
               state_d     = IDLE;
               frame_err_o = 1'b1;
            end else if (byte_ok) begin
               route      = 1'b1;
               route_dir  = DIR_ADDR;
               route_code = ACODE_BYTE;
               state_d    = (state_q == WR_A) ? WR_D : RD_X;
            end
         end
         WR_D, OPA_W, OPB_W: begin
            if (wait_err) begin
               state_d     = IDLE;
               frame_err_o = 1'b1;
            end else if (byte_ok) begin
               route      = 1'b1;
               route_dir  = DIR_DATA;
               route_code = code_hold_q;
               state_d    = (state_q == WR_D)  ? WR_X :
                            (state_q == OPA_W) ? OPA_AD : OPB_AD;
            end
         end
         FUN_W: begin
            alu_clk_en_o = 1'b1;
            if (wait_err) begin
               state_d     = IDLE;
               frame_err_o = 1'b1;
            end else if (byte_ok) begin
               route      = 1'b1;
               route_dir  = DIR_FUN;
               route_code = code_hold_q;
               state_d    = ALU_X;
            end
         end
         OPA_AD: begin
            route      = 1'b1;
            route_dir  = DIR_ADDR;
            route_code = ACODE_A0;
            state_d    = OPA_X;
         end
         OPB_AD: begin
            route      = 1'b1;
            route_dir  = DIR_ADDR;
            route_code = ACODE_A1;
            state_d    = OPB_X;
         end
         WR_X: begin
            reg_wr_en_o  = 1'b1;
            frame_done_o = 1'b1;
            state_d      = IDLE;
         end
         RD_X: begin
            reg_rd_en_o  = 1'b1;
            frame_done_o = 1'b1;
            state_d      = IDLE;
         end
         OPA_X: begin
            reg_wr_en_o = 1'b1;
            state_d     = OPB_W;
         end
         OPB_X: begin
            reg_wr_en_o = 1'b1;
            state_d     = FUN_W;
         end
         ALU_X: begin
            alu_en_o     = 1'b1;
            alu_clk_en_o = 1'b1;
            frame_done_o = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (route) begin
         block_dir_o = route_dir;
         addr_code_o = route_code;
         dir_hold_d  = route_dir;
         code_hold_d = route_code;
      end

      // Reset silences the Mealy outputs at once, even with a byte on the pins.
      if (!RST) begin
         cmd_analyze_en_o = 1'b0;
         block_dir_o      = DIR_CLR;
         addr_code_o      = ACODE_NONE;
         frame_err_o      = 1'b0;
      end
   end

endmodule

// File: doc/rx_cmd_seq.md
# rx_cmd_seq

Receive-side command sequencer for the system controller. It consumes the byte stream from the UART RX (one `rx_valid` pulse per byte) and drives the frame analyzer's control pins (`cmd_analyze_en`, `block_dir`, `addr_code`). It then issues register-file write/read strobes and the ALU enable/clock-gate for each command frame. Frames: `AA addr data` (write), `BB addr` (read), `CC opA opB fun` (ALU with operands), `DD fun` (ALU, no operands).

## Interface
- `TIMEOUT_CYC`, 255: maximum idle cycles allowed between bytes of one frame.
- `CNT_WIDTH`, 8: timeout counter width; `TIMEOUT_CYC` must be < 2^CNT_WIDTH.
- `CLK` input 1: system clock.
- `RST` input 1: reset, asynchronous, active-low.
- `rx_valid` input 1: one-cycle pulse, new RX byte present; byte stays stable until the next pulse.
- `rx_err` input 1: parity/stop error, qualified by `rx_valid`.
- `cmd_code` input 3: decoded command from the analyzer. 001 wr, 010 rd, 011 alu_op, 100 alu_nop, 000 invalid.
- `cmd_analyze_en` output 1: analyzer latches the command byte.
- `block_dir` output 2: analyzer routing. 00 clear, 01 alu_fun, 10 reg_addr, 11 reg_wr_data.
- `addr_code` output 2: analyzer address select. 01 byte, 10 addr 0x0, 11 addr 0x1.
- `reg_wr_en` output 1: one-cycle register write strobe.
- `reg_rd_en` output 1: one-cycle register read strobe.
- `alu_en` output 1: one-cycle ALU execute strobe.
- `alu_clk_en` output 1: ALU clock-gate enable.
- `frame_done` output 1: one-cycle pulse when a frame completes.
- `frame_err` output 1: one-cycle pulse when a frame aborts.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, CMD_DEC, WR_A, WR_D, WR_X, RD_A, RD_X, OPA_W, OPA_AD, OPA_X, OPB_W, OPB_AD, OPB_X, FUN_W, ALU_X.
- Outputs are a Mealy function of state, `rx_valid` and `rx_err`. `dir_hold`/`code_hold` registers keep the last routing code issued in the current frame.
- IDLE:
  - `block_dir`=00 and `cmd_analyze_en`=`rx_valid & ~rx_err`.
  - A good byte moves the FSM to CMD_DEC; a byte with `rx_err` set is dropped with no `frame_err`.
- CMD_DEC: branch on `cmd_code`.
  - 001→WR_A, 010→RD_A, 011→OPA_W, 100→FUN_W.
  - 000→IDLE with a `frame_err` pulse.
- Routing happens on the cycle a wait state sees `rx_valid`:
  - WR_A / RD_A: 10/01.
  - WR_D: 11.
  - OPA_W / OPB_W: 11.
  - FUN_W: 01.
- Fixed routing cycles, with no byte consumed:
  - OPA_AD: 10/10.
  - OPB_AD: 10/11.
- Hold rule: in every non-IDLE cycle without a routing action, drive `dir_hold`/`code_hold`. CMD_DEC holds 00. This re-latch is idempotent because the RX byte is stable.
- Flows:
  - Write: WR_A→WR_D→WR_X (`reg_wr_en`, `frame_done`).
  - Read: RD_A→RD_X (`reg_rd_en`, `frame_done`).
  - ALU with operands: OPA_W→OPA_AD→OPA_X (`reg_wr_en`)→OPB_W→OPB_AD→OPB_X (`reg_wr_en`)→FUN_W→ALU_X (`alu_en`, `frame_done`).
  - ALU without operands: FUN_W→ALU_X.
- Every X state returns to IDLE. `alu_clk_en` is high in FUN_W and ALU_X.
- Timeout:
  - The counter clears on entry to any wait state (WR_A, WR_D, RD_A, OPA_W, OPB_W, FUN_W) and on `rx_valid`, and increments otherwise.
  - When the counter equals `TIMEOUT_CYC` in a wait state: `frame_err`, go to IDLE.
- Error: `rx_valid & rx_err` in any wait state gives `frame_err`, go to IDLE, with no routing that cycle.

## Timing
- Reset: state IDLE, all outputs 0, `block_dir`=00, `addr_code`=00, counter 0, hold registers 00.
- The analyzer updates one edge after a routing cycle, so strobes occur exactly one cycle after the last routing cycle.
- Write frame: `reg_wr_en` asserts the cycle after the data byte's `rx_valid`.
- Operand byte: data route (cycle k), address route (k+1), `reg_wr_en` (k+2).
- ALU frame: `alu_en` asserts the cycle after the fun byte's `rx_valid`.
- `rx_valid` arriving in a non-wait state (CMD_DEC, AD, X states) is ignored. The upstream byte rate guarantees ≥4 cycles between bytes.
- A reset asserted mid-frame forces IDLE and zero outputs immediately (asynchronous); no `frame_err` is generated.
- `frame_done` and `frame_err` never assert in the same cycle.

## Test plan
- Write frame: AA, 05, 3C → `reg_wr_en` for 1 cycle, exactly 1 cycle after the 3C pulse; `frame_done` in the same cycle; `block_dir` sequence 10/01 then 11.
- Read frame: BB, 07 → `reg_rd_en` for 1 cycle after the 07 pulse; `busy` falls next cycle; no `reg_wr_en`.
- ALU frame: CC, 12, 34, 02 → two `reg_wr_en` pulses with `addr_code` 10 then 11; `alu_en` 1 cycle after 02; `alu_clk_en` high from FUN_W entry through ALU_X.
- No-operand frame: DD, 01 → `alu_en` only; invalid byte 5A → `frame_err` pulse in CMD_DEC, back to IDLE.
- Timeout: AA, 05, then silence → `frame_err` exactly `TIMEOUT_CYC` cycles after WR_D entry; a following AA frame executes normally.
- Reset and errors:
  - `RST` low during OPB_W → all outputs 0 immediately.
  - `rx_err` on opB → `frame_err`, no second `reg_wr_en`.
